// File: rtl/sparhixcel_pkg.sv
// ---------------------------------------------------------------------------
// sparhixcel_pkg
// Shared types and helpers for the SparHiXcel host I/O bridge.
//   io_target_e   : load command target (feature / weight / signal / reserved)
//   load_state_e  : load-path FSM states
//   drain_state_e : drain-path FSM states
//   ceil_div      : integer ceiling division used to size line beat counts
//   LINE_W_* / BEATS_* : line widths and beats per line for the default
//                        array geometry (20x20, 8-bit elements, 32-bit host)
// ---------------------------------------------------------------------------
package sparhixcel_pkg;

    typedef enum logic [1:0] {
        TGT_FEAT = 2'd0,
        TGT_WGT  = 2'd1,
        TGT_SIG  = 2'd2,
        TGT_RSVD = 2'd3
    } io_target_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_COLLECT,
        L_WRITE,
        L_DONE
    } load_state_e;

    typedef enum logic {
        D_IDLE,
        D_SEND
    } drain_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int DEF_N_ROWS        = 20;
    localparam int DEF_I_WIDTH       = 8;
    localparam int DEF_F_WIDTH       = 8;
    localparam int DEF_ROM_SIG_WIDTH = 180;
    localparam int DEF_HOST_WIDTH    = 32;

    localparam int LINE_W_FEAT = DEF_N_ROWS * DEF_I_WIDTH;
    localparam int LINE_W_WGT  = DEF_N_ROWS * DEF_F_WIDTH;
    localparam int LINE_W_SIG  = DEF_ROM_SIG_WIDTH;

    localparam int BEATS_FEAT = ceil_div(LINE_W_FEAT, DEF_HOST_WIDTH);
    localparam int BEATS_WGT  = ceil_div(LINE_W_WGT, DEF_HOST_WIDTH);
    localparam int BEATS_SIG  = ceil_div(LINE_W_SIG, DEF_HOST_WIDTH);

endpackage

// File: rtl/sparhixcel_beat_packer.sv
// ---------------------------------------------------------------------------
// sparhixcel_beat_packer
// Assembles host payload beats into one memory line. Beat k lands at bits
// [k*HOST_WIDTH +: HOST_WIDTH]; the counter wraps after last_idx_i.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clear_i        : restart the beat counter (new command)
//   beat_fire_i    : a beat is transferred this cycle
//   beat_data_i    : beat payload
//   last_idx_i     : index of the final beat of a line for the current target
//   line_o         : line contents including the beat transferred this cycle
//   line_done_o    : the beat transferred this cycle completes the line
// ---------------------------------------------------------------------------
module sparhixcel_beat_packer #(
    parameter int HOST_WIDTH = 32,
    parameter int MAX_BEATS  = 6,
    parameter int CNT_W      = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         beat_fire_i,
    input  logic [HOST_WIDTH-1:0]        beat_data_i,
    input  logic [CNT_W-1:0]             last_idx_i,
    output logic [MAX_BEATS*HOST_WIDTH-1:0] line_o,
    output logic                         line_done_o
);

    localparam int PACK_W = MAX_BEATS * HOST_WIDTH;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PACK_W-1:0] line_q, line_d;

    // Stale bits above the current target's line width are left in place;
    // the top masks them off when forming the write data.
    always_comb begin
        cnt_d       = cnt_q;
        line_d      = line_q;
        line_done_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_fire_i) begin
            line_d[cnt_q*HOST_WIDTH +: HOST_WIDTH] = beat_data_i;
            if (cnt_q == last_idx_i) begin
                cnt_d       = '0;
                line_done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign line_o = line_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/sparhixcel_io_bridge.sv
// ---------------------------------------------------------------------------
// sparhixcel_io_bridge
// Host-side I/O bridge for the SparHiXcel accelerator.
// Load path : command (target/base/lines) + HOST_WIDTH beat stream, packed
//             into lines and written with registered strobes, auto-incrementing
//             address, one-cycle load_done_o pulse at the end.
// Drain path: snapshot of all column results on res_capture_i, streamed out
//             over valid/ready for the active column count.
// Ports:
//   clk_i, general_rst_ni            clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o          load command handshake
//   cmd_target_i/base_i/lines_i      command fields
//   beat_valid_i/ready_o/data_i      payload beat handshake
//   wr_feat_o/wr_wgt_o/wr_sig_o      memory write strobes
//   wr_addr_o/wr_data_o              write address / packed line
//   load_done_o                      end-of-command pulse
//   n_cols_i, res_capture_i, res_i   drain column count, snapshot strobe, results
//   res_valid_o/ready_i/data_o       result stream handshake and data
//   res_col_o, res_last_o            column index, final-column flag
//   overflow_o                       sticky dropped-capture flag
// ---------------------------------------------------------------------------
module sparhixcel_io_bridge
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY    = 20,
    parameter int N_COLS_ARRAY    = 20,
    parameter int I_WIDTH         = 8,
    parameter int F_WIDTH         = 8,
    parameter int ROM_SIG_WIDTH   = 180,
    parameter int FEAT_ADDR_WIDTH = 16,
    parameter int SIG_ADDR_WIDTH  = 5,
    parameter int HOST_WIDTH      = 32
) (
    input  logic                                    clk_i,
    input  logic                                    general_rst_ni,
    input  logic                                    cmd_valid_i,
    output logic                                    cmd_ready_o,
    input  logic [1:0]                              cmd_target_i,
    input  logic [FEAT_ADDR_WIDTH-1:0]              cmd_base_i,
    input  logic [FEAT_ADDR_WIDTH-1:0]              cmd_lines_i,
    input  logic                                    beat_valid_i,
    output logic                                    beat_ready_o,
    input  logic [HOST_WIDTH-1:0]                   beat_data_i,
    output logic                                    wr_feat_o,
    output logic                                    wr_wgt_o,
    output logic                                    wr_sig_o,
    output logic [FEAT_ADDR_WIDTH-1:0]              wr_addr_o,
    output logic [ROM_SIG_WIDTH-1:0]                wr_data_o,
    output logic                                    load_done_o,
    input  logic [$clog2(N_COLS_ARRAY+1)-1:0]       n_cols_i,
    input  logic                                    res_capture_i,
    input  logic [N_COLS_ARRAY*(F_WIDTH+I_WIDTH)-1:0] res_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic signed [F_WIDTH+I_WIDTH-1:0]       res_data_o,
    output logic [$clog2(N_COLS_ARRAY)-1:0]         res_col_o,
    output logic                                    res_last_o,
    output logic                                    overflow_o
);

    localparam int LW_FEAT    = N_ROWS_ARRAY * I_WIDTH;
    localparam int LW_WGT     = N_ROWS_ARRAY * F_WIDTH;
    localparam int LW_SIG     = ROM_SIG_WIDTH;
    localparam int NB_FEAT    = ceil_div(LW_FEAT, HOST_WIDTH);
    localparam int NB_WGT     = ceil_div(LW_WGT, HOST_WIDTH);
    localparam int NB_SIG     = ceil_div(LW_SIG, HOST_WIDTH);
    localparam int NB_FW      = (NB_FEAT > NB_WGT) ? NB_FEAT : NB_WGT;
    localparam int NB_MAX     = (NB_FW > NB_SIG) ? NB_FW : NB_SIG;
    localparam int PACK_W     = NB_MAX * HOST_WIDTH;
    localparam int CNT_W      = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;
    localparam int RES_W      = F_WIDTH + I_WIDTH;
    localparam int NC_W       = $clog2(N_COLS_ARRAY + 1);
    localparam int COL_W      = $clog2(N_COLS_ARRAY);

    localparam logic [PACK_W-1:0] MASK_FEAT = {PACK_W{1'b1}} >> (PACK_W - LW_FEAT);
    localparam logic [PACK_W-1:0] MASK_WGT  = {PACK_W{1'b1}} >> (PACK_W - LW_WGT);
    localparam logic [PACK_W-1:0] MASK_SIG  = {PACK_W{1'b1}} >> (PACK_W - LW_SIG);

    // ------------------------------------------------------------------ load
    load_state_e                  lstate_q, lstate_d;
    io_target_e                   target_q, target_d;
    logic [FEAT_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [FEAT_ADDR_WIDTH-1:0]   lines_q, lines_d;
    logic [FEAT_ADDR_WIDTH-1:0]   line_idx_q, line_idx_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         beat_ready_q, beat_ready_d;
    logic                         wr_feat_q, wr_feat_d;
    logic                         wr_wgt_q, wr_wgt_d;
    logic                         wr_sig_q, wr_sig_d;
    logic [FEAT_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ROM_SIG_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                         load_done_q, load_done_d;

    logic                         cmd_accept;
    logic                         beat_fire;
    logic [CNT_W-1:0]             last_beat_idx;
    logic [PACK_W-1:0]            packed_line;
    logic                         line_done;
    logic [FEAT_ADDR_WIDTH-1:0]   line_addr;
    logic [PACK_W-1:0]            line_mask;

    // Handshakes use the registered ready, so nothing is accepted on the
    // first cycle after reset release.
    assign cmd_accept = cmd_valid_i && cmd_ready_q;
    assign beat_fire  = beat_valid_i && beat_ready_q;

    always_comb begin
        last_beat_idx = CNT_W'(NB_FEAT - 1);
        line_mask     = MASK_FEAT;
        case (target_q)
            TGT_WGT: begin
                last_beat_idx = CNT_W'(NB_WGT - 1);
                line_mask     = MASK_WGT;
            end
            TGT_SIG: begin
                last_beat_idx = CNT_W'(NB_SIG - 1);
                line_mask     = MASK_SIG;
            end
            default: ;
        endcase
    end

    sparhixcel_beat_packer #(
        .HOST_WIDTH (HOST_WIDTH),
        .MAX_BEATS  (NB_MAX),
        .CNT_W      (CNT_W)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_ni      (general_rst_ni),
        .clear_i     (cmd_accept),
        .beat_fire_i (beat_fire),
        .beat_data_i (beat_data_i),
        .last_idx_i  (last_beat_idx),
        .line_o      (packed_line),
        .line_done_o (line_done)
    );

    assign line_addr = base_q + line_idx_q;

    // All load outputs are registered from the next state so strobe, address
    // and data appear together for exactly the L_WRITE cycle.
    always_comb begin
        lstate_d   = lstate_q;
        target_d   = target_q;
        base_d     = base_q;
        lines_d    = lines_q;
        line_idx_d = line_idx_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (lstate_q)
            L_IDLE: begin
                if (cmd_accept) begin
                    target_d   = io_target_e'(cmd_target_i);
                    base_d     = cmd_base_i;
                    lines_d    = cmd_lines_i;
                    line_idx_d = '0;
                    if (cmd_lines_i == '0 || cmd_target_i == TGT_RSVD) begin
                        lstate_d = L_DONE;
                    end else begin
                        lstate_d = L_COLLECT;
                    end
                end
            end
            L_COLLECT: begin
                if (line_done) begin
                    lstate_d  = L_WRITE;
                    wr_data_d = ROM_SIG_WIDTH'(packed_line & line_mask);
                    if (target_q == TGT_SIG) begin
                        wr_addr_d = {{(FEAT_ADDR_WIDTH-SIG_ADDR_WIDTH){1'b0}},
                                     line_addr[SIG_ADDR_WIDTH-1:0]};
                    end else begin
                        wr_addr_d = line_addr;
                    end
                end
            end
            L_WRITE: begin
                if (line_idx_q == lines_q - FEAT_ADDR_WIDTH'(1)) begin
                    lstate_d = L_DONE;
                end else begin
                    lstate_d   = L_COLLECT;
                    line_idx_d = line_idx_q + FEAT_ADDR_WIDTH'(1);
                end
            end
            default: begin
                lstate_d = L_IDLE;
            end
        endcase
        cmd_ready_d  = (lstate_d == L_IDLE);
        beat_ready_d = (lstate_d == L_COLLECT);
        load_done_d  = (lstate_d == L_DONE);
        wr_feat_d    = (lstate_d == L_WRITE) && (target_d == TGT_FEAT);
        wr_wgt_d     = (lstate_d == L_WRITE) && (target_d == TGT_WGT);
        wr_sig_d     = (lstate_d == L_WRITE) && (target_d == TGT_SIG);
    end

    always_ff @(posedge clk_i) begin
        if (!general_rst_ni) begin
            lstate_q     <= L_IDLE;
            target_q     <= TGT_FEAT;
            base_q       <= '0;
            lines_q      <= '0;
            line_idx_q   <= '0;
            cmd_ready_q  <= 1'b0;
            beat_ready_q <= 1'b0;
            wr_feat_q    <= 1'b0;
            wr_wgt_q     <= 1'b0;
            wr_sig_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
        end else begin
            lstate_q     <= lstate_d;
            target_q     <= target_d;
            base_q       <= base_d;
            lines_q      <= lines_d;
            line_idx_q   <= line_idx_d;
            cmd_ready_q  <= cmd_ready_d;
            beat_ready_q <= beat_ready_d;
            wr_feat_q    <= wr_feat_d;
            wr_wgt_q     <= wr_wgt_d;
            wr_sig_q     <= wr_sig_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign beat_ready_o = beat_ready_q;
    assign wr_feat_o    = wr_feat_q;
    assign wr_wgt_o     = wr_wgt_q;
    assign wr_sig_o     = wr_sig_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign load_done_o  = load_done_q;

    // ----------------------------------------------------------------- drain
    drain_state_e                         dstate_q, dstate_d;
    logic [N_COLS_ARRAY-1:0][RES_W-1:0]   snap_q, snap_d;
    logic [COL_W-1:0]                     col_q, col_d;
    logic [COL_W-1:0]                     last_col_q, last_col_d;
    logic                                 overflow_q, overflow_d;

    logic                                 res_fire;
    logic                                 at_last;
    logic [COL_W-1:0]                     eff_last_col;

    // 0 or anything above the array width means "all columns".
    assign eff_last_col = (n_cols_i == '0 || n_cols_i > NC_W'(N_COLS_ARRAY))
                        ? COL_W'(N_COLS_ARRAY - 1)
                        : COL_W'(n_cols_i - NC_W'(1));

    assign res_fire = (dstate_q == D_SEND) && res_ready_i;
    assign at_last  = (col_q == last_col_q);

    // A capture is only taken when idle or on the final handshake, so the
    // burst in flight is never corrupted; any other capture is dropped.
    always_comb begin
        dstate_d   = dstate_q;
        snap_d     = snap_q;
        col_d      = col_q;
        last_col_d = last_col_q;
        overflow_d = overflow_q;
        case (dstate_q)
            D_IDLE: begin
                if (res_capture_i) begin
                    snap_d     = res_i;
                    col_d      = '0;
                    last_col_d = eff_last_col;
                    dstate_d   = D_SEND;
                end
            end
            default: begin
                if (res_fire && at_last) begin
                    if (res_capture_i) begin
                        snap_d     = res_i;
                        col_d      = '0;
                        last_col_d = eff_last_col;
                    end else begin
                        dstate_d = D_IDLE;
                    end
                end else begin
                    if (res_fire) begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (res_capture_i) begin
                        overflow_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!general_rst_ni) begin
            dstate_q   <= D_IDLE;
            snap_q     <= '0;
            col_q      <= '0;
            last_col_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            dstate_q   <= dstate_d;
            snap_q     <= snap_d;
            col_q      <= col_d;
            last_col_q <= last_col_d;
            overflow_q <= overflow_d;
        end
    end

    assign res_valid_o = (dstate_q == D_SEND);
    assign res_data_o  = snap_q[col_q];
    assign res_col_o   = col_q;
    assign res_last_o  = (dstate_q == D_SEND) && at_last;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_sparhixcel_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_sparhixcel_io_bridge
// Directed bench for the SparHiXcel host I/O bridge: reset, line loads to
// each target, degenerate commands, result draining with stalls, column
// clamping, dropped capture and capture on the final handshake.
// ---------------------------------------------------------------------------
module tb_sparhixcel_io_bridge;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [1:0]   cmd_target_i;
    logic [15:0]  cmd_base_i;
    logic [15:0]  cmd_lines_i;
    logic         beat_valid_i;
    logic         beat_ready_o;
    logic [31:0]  beat_data_i;
    logic         wr_feat_o;
    logic         wr_wgt_o;
    logic         wr_sig_o;
    logic [15:0]  wr_addr_o;
    logic [179:0] wr_data_o;
    logic         load_done_o;
    logic [4:0]   n_cols_i;
    logic         res_capture_i;
    logic [319:0] res_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic signed [15:0] res_data_o;
    logic [4:0]   res_col_o;
    logic         res_last_o;
    logic         overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    // load observations
    int           wr_cnt;
    logic [2:0]   wr_kind [8];
    logic [15:0]  wr_addr_rec [8];
    logic [179:0] wr_data_rec [8];
    int           done_cnt;
    int           done_cyc;
    int           beats_sent;

    // drain observations
    int           n_xfer;
    logic [15:0]  x_data [32];
    int           x_col [32];
    logic         x_last [32];
    int           stall_bad;

    sparhixcel_io_bridge dut (
        .clk_i          (clk),
        .general_rst_ni (rst_n),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_target_i   (cmd_target_i),
        .cmd_base_i     (cmd_base_i),
        .cmd_lines_i    (cmd_lines_i),
        .beat_valid_i   (beat_valid_i),
        .beat_ready_o   (beat_ready_o),
        .beat_data_i    (beat_data_i),
        .wr_feat_o      (wr_feat_o),
        .wr_wgt_o       (wr_wgt_o),
        .wr_sig_o       (wr_sig_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .load_done_o    (load_done_o),
        .n_cols_i       (n_cols_i),
        .res_capture_i  (res_capture_i),
        .res_i          (res_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .res_col_o      (res_col_o),
        .res_last_o     (res_last_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_res(input int base);
        for (int k = 0; k < 20; k++) res_i[k*16 +: 16] = 16'(base + k);
    endtask

    task automatic observe(input int cyc);
        if (wr_feat_o || wr_wgt_o || wr_sig_o) begin
            if (wr_cnt < 8) begin
                wr_kind[wr_cnt]     = {wr_sig_o, wr_wgt_o, wr_feat_o};
                wr_addr_rec[wr_cnt] = wr_addr_o;
                wr_data_rec[wr_cnt] = wr_data_o;
            end
            wr_cnt++;
        end
        if (load_done_o) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_cnt++;
        end
    endtask

    // Issues one command and feeds beats whenever ready; beat value is the
    // running beat index, or all ones when requested.
    task automatic run_load(input logic [1:0] tgt, input logic [15:0] base,
                            input logic [15:0] lines, input logic ones);
        int  w;
        logic rdy;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; beats_sent = 0;
        cmd_target_i = tgt; cmd_base_i = base; cmd_lines_i = lines;
        cmd_valid_i = 1'b1;
        w = 0;
        while (!cmd_ready_o && w < 20) begin step(); w++; end
        step();
        cmd_valid_i = 1'b0;
        observe(0);
        for (int cyc = 1; cyc <= 200 && done_cnt == 0; cyc++) begin
            rdy          = beat_ready_o;
            beat_valid_i = rdy;
            beat_data_i  = ones ? 32'hFFFF_FFFF : 32'(beats_sent);
            @(posedge clk);
            if (rdy) beats_sent++;
            #1;
            beat_valid_i = 1'b0;
            observe(cyc);
        end
    endtask

    // Drains one burst; toggle=1 drives ready 1,0,1,0..., else ready held high.
    task automatic run_drain(input logic toggle);
        logic        r;
        logic        stall_pend;
        logic [15:0] saved_data;
        logic [4:0]  saved_col;
        logic        got_last;
        n_xfer = 0; stall_bad = 0; stall_pend = 1'b0; got_last = 1'b0;
        saved_data = '0; saved_col = '0;
        for (int cyc = 0; cyc < 60 && !got_last; cyc++) begin
            r = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stall_pend && (res_data_o !== saved_data || res_col_o !== saved_col))
                stall_bad++;
            stall_pend = res_valid_o && !r;
            saved_data = res_data_o;
            saved_col  = res_col_o;
            if (res_valid_o && r) begin
                if (n_xfer < 32) begin
                    x_data[n_xfer] = res_data_o;
                    x_col[n_xfer]  = int'(res_col_o);
                    x_last[n_xfer] = res_last_o;
                end
                n_xfer++;
                if (res_last_o) got_last = 1'b1;
            end
            res_ready_i = r;
            step();
        end
        res_ready_i = 1'b0;
    endtask

    task automatic capture(input int base, input logic [4:0] ncols);
        set_res(base);
        n_cols_i      = ncols;
        res_capture_i = 1'b1;
        step();
        res_capture_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(); step();
        cmd_target_i = 2'd0; cmd_base_i = 16'h0010; cmd_lines_i = 16'd2;
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i  = 1'b0;
        beat_valid_i = 1'b1; beat_data_i = 32'hDEAD_BEEF;
        step(); step();
        beat_valid_i = 1'b0;
        capture(100, 5'd3);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({cmd_ready_o, beat_ready_o, wr_feat_o, wr_wgt_o, wr_sig_o, load_done_o,
                         res_valid_o, res_last_o, overflow_o} !== 9'b0)
            $display("[TB] FAIL reset_flags: got %b expected 0", {cmd_ready_o, beat_ready_o,
                     wr_feat_o, wr_wgt_o, wr_sig_o, load_done_o, res_valid_o, res_last_o, overflow_o});
            else n_pass++;
        n_checks++; if (wr_addr_o !== 16'h0) $display("[TB] FAIL reset_wr_addr: got %h expected 0", wr_addr_o); else n_pass++;
        n_checks++; if (wr_data_o !== 180'h0) $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data_o); else n_pass++;
        n_checks++; if (res_data_o !== 16'sh0) $display("[TB] FAIL reset_res_data: got %h expected 0", res_data_o); else n_pass++;
        n_checks++; if (res_col_o !== 5'h0) $display("[TB] FAIL reset_res_col: got %h expected 0", res_col_o); else n_pass++;
        rst_n = 1'b1;
        n_checks++; if (cmd_ready_o !== 1'b0) $display("[TB] FAIL ready_before_edge: got %b expected 0", cmd_ready_o); else n_pass++;
        step();
        n_checks++; if (cmd_ready_o !== 1'b1) $display("[TB] FAIL ready_after_release: got %b expected 1", cmd_ready_o); else n_pass++;
        n_checks++; if (beat_ready_o !== 1'b0) $display("[TB] FAIL beat_ready_after_release: got %b expected 0", beat_ready_o); else n_pass++;
    endtask

    task automatic test_feature_load();
        logic [179:0] exp0, exp1;
        exp0 = '0; exp1 = '0;
        for (int k = 0; k < 5; k++) begin
            exp0[k*32 +: 32] = 32'(k);
            exp1[k*32 +: 32] = 32'(k + 5);
        end
        run_load(2'd0, 16'h0010, 16'd2, 1'b0);
        n_checks++; if (wr_cnt !== 2) $display("[TB] FAIL feat_wr_count: got %0d expected 2", wr_cnt); else n_pass++;
        n_checks++; if (wr_kind[0] !== 3'b001 || wr_kind[1] !== 3'b001)
            $display("[TB] FAIL feat_strobe: got %b/%b expected 001/001", wr_kind[0], wr_kind[1]); else n_pass++;
        n_checks++; if (wr_addr_rec[0] !== 16'h0010) $display("[TB] FAIL feat_addr0: got %h expected 0010", wr_addr_rec[0]); else n_pass++;
        n_checks++; if (wr_addr_rec[1] !== 16'h0011) $display("[TB] FAIL feat_addr1: got %h expected 0011", wr_addr_rec[1]); else n_pass++;
        n_checks++; if (wr_data_rec[0] !== exp0) $display("[TB] FAIL feat_data0: got %h expected %h", wr_data_rec[0], exp0); else n_pass++;
        n_checks++; if (wr_data_rec[1] !== exp1) $display("[TB] FAIL feat_data1: got %h expected %h", wr_data_rec[1], exp1); else n_pass++;
        n_checks++; if (beats_sent !== 10) $display("[TB] FAIL feat_beats: got %0d expected 10", beats_sent); else n_pass++;
        n_checks++; if (done_cnt !== 1 || done_cyc !== 12)
            $display("[TB] FAIL feat_done_cycle: got %0d (count %0d) expected 12", done_cyc, done_cnt); else n_pass++;
        step();
        n_checks++; if (load_done_o !== 1'b0 || cmd_ready_o !== 1'b1)
            $display("[TB] FAIL feat_done_pulse: got done=%b ready=%b expected 0/1", load_done_o, cmd_ready_o); else n_pass++;
    endtask

    task automatic test_signal_load();
        logic [179:0] ones;
        ones = '1;
        run_load(2'd2, 16'h0023, 16'd1, 1'b1);
        n_checks++; if (wr_cnt !== 1 || wr_kind[0] !== 3'b100)
            $display("[TB] FAIL sig_strobe: got count %0d kind %b expected 1/100", wr_cnt, wr_kind[0]); else n_pass++;
        n_checks++; if (wr_addr_rec[0] !== 16'h0003) $display("[TB] FAIL sig_addr: got %h expected 0003", wr_addr_rec[0]); else n_pass++;
        n_checks++; if (wr_data_rec[0] !== ones) $display("[TB] FAIL sig_data: got %h expected %h", wr_data_rec[0], ones); else n_pass++;
        n_checks++; if (beats_sent !== 6 || done_cyc !== 7)
            $display("[TB] FAIL sig_timing: got beats %0d done %0d expected 6/7", beats_sent, done_cyc); else n_pass++;
        step();
        n_checks++; if (wr_sig_o !== 1'b0) $display("[TB] FAIL sig_strobe_drop: got %b expected 0", wr_sig_o); else n_pass++;
    endtask

    task automatic test_weight_wrap();
        logic [179:0] exp0, exp1;
        exp0 = '0; exp1 = '0;
        for (int k = 0; k < 5; k++) begin
            exp0[k*32 +: 32] = 32'(k);
            exp1[k*32 +: 32] = 32'(k + 5);
        end
        run_load(2'd1, 16'hFFFF, 16'd2, 1'b0);
        n_checks++; if (wr_cnt !== 2 || wr_kind[0] !== 3'b010 || wr_kind[1] !== 3'b010)
            $display("[TB] FAIL wgt_strobe: got count %0d kinds %b/%b expected 2 010/010", wr_cnt, wr_kind[0], wr_kind[1]); else n_pass++;
        n_checks++; if (wr_addr_rec[0] !== 16'hFFFF || wr_addr_rec[1] !== 16'h0000)
            $display("[TB] FAIL wgt_addr_wrap: got %h/%h expected FFFF/0000", wr_addr_rec[0], wr_addr_rec[1]); else n_pass++;
        n_checks++; if (wr_data_rec[0] !== exp0 || wr_data_rec[1] !== exp1)
            $display("[TB] FAIL wgt_data: got %h expected %h", wr_data_rec[0], exp0); else n_pass++;
        step();
    endtask

    task automatic test_empty_commands();
        run_load(2'd0, 16'h0040, 16'd0, 1'b0);
        n_checks++; if (wr_cnt !== 0 || done_cyc !== 0)
            $display("[TB] FAIL zero_lines: got writes %0d done %0d expected 0/0", wr_cnt, done_cyc); else n_pass++;
        step();
        n_checks++; if (load_done_o !== 1'b0 || cmd_ready_o !== 1'b1)
            $display("[TB] FAIL zero_lines_pulse: got done=%b ready=%b expected 0/1", load_done_o, cmd_ready_o); else n_pass++;
        run_load(2'd3, 16'h0040, 16'd4, 1'b0);
        n_checks++; if (wr_cnt !== 0 || done_cyc !== 0 || beats_sent !== 0)
            $display("[TB] FAIL reserved_target: got writes %0d done %0d beats %0d expected 0/0/0",
                     wr_cnt, done_cyc, beats_sent); else n_pass++;
        step();
    endtask

    task automatic test_drain();
        capture(100, 5'd3);
        run_drain(1'b1);
        n_checks++; if (n_xfer !== 3) $display("[TB] FAIL drain_count: got %0d expected 3", n_xfer); else n_pass++;
        n_checks++; if (x_data[0] !== 16'd100 || x_data[1] !== 16'd101 || x_data[2] !== 16'd102)
            $display("[TB] FAIL drain_data: got %0d,%0d,%0d expected 100,101,102", x_data[0], x_data[1], x_data[2]); else n_pass++;
        n_checks++; if (x_col[0] !== 0 || x_col[1] !== 1 || x_col[2] !== 2)
            $display("[TB] FAIL drain_cols: got %0d,%0d,%0d expected 0,1,2", x_col[0], x_col[1], x_col[2]); else n_pass++;
        n_checks++; if ({x_last[0], x_last[1], x_last[2]} !== 3'b001)
            $display("[TB] FAIL drain_last: got %b expected 001", {x_last[0], x_last[1], x_last[2]}); else n_pass++;
        n_checks++; if (stall_bad !== 0) $display("[TB] FAIL drain_stall_stable: got %0d changes expected 0", stall_bad); else n_pass++;
        n_checks++; if (res_valid_o !== 1'b0 || overflow_o !== 1'b0)
            $display("[TB] FAIL drain_end: got valid=%b ovf=%b expected 0/0", res_valid_o, overflow_o); else n_pass++;
    endtask

    task automatic test_drain_clamp();
        capture(100, 5'd0);
        run_drain(1'b0);
        n_checks++; if (n_xfer !== 20 || x_data[19] !== 16'd119 || x_last[18] !== 1'b0)
            $display("[TB] FAIL clamp_zero: got %0d xfers last data %0d expected 20/119", n_xfer, x_data[19]); else n_pass++;
        capture(100, 5'd25);
        run_drain(1'b0);
        n_checks++; if (n_xfer !== 20 || x_col[19] !== 19)
            $display("[TB] FAIL clamp_high: got %0d xfers last col %0d expected 20/19", n_xfer, x_col[19]); else n_pass++;
    endtask

    task automatic test_overflow();
        capture(100, 5'd3);
        res_ready_i = 1'b1;
        step();
        res_ready_i   = 1'b0;
        res_capture_i = 1'b1;
        set_res(200);
        step();
        res_capture_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", overflow_o); else n_pass++;
        n_checks++; if (res_data_o !== 16'sd101 || res_col_o !== 5'd1)
            $display("[TB] FAIL ovf_stream_hold: got %0d col %0d expected 101/1", res_data_o, res_col_o); else n_pass++;
        run_drain(1'b0);
        n_checks++; if (n_xfer !== 2 || x_data[0] !== 16'd101 || x_data[1] !== 16'd102 || x_last[1] !== 1'b1)
            $display("[TB] FAIL ovf_stream_rest: got %0d xfers %0d,%0d expected 2 101,102", n_xfer, x_data[0], x_data[1]); else n_pass++;
        n_checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        n_checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL ovf_cleared: got %b expected 0", overflow_o); else n_pass++;
        capture(100, 5'd3);
        res_ready_i = 1'b1;
        step(); step();
        n_checks++; if (res_last_o !== 1'b1 || res_data_o !== 16'sd102)
            $display("[TB] FAIL b2b_at_last: got last=%b data %0d expected 1/102", res_last_o, res_data_o); else n_pass++;
        res_capture_i = 1'b1;
        set_res(300);
        step();
        res_capture_i = 1'b0;
        res_ready_i   = 1'b0;
        n_checks++; if (res_valid_o !== 1'b1 || res_col_o !== 5'd0 || res_data_o !== 16'sd300)
            $display("[TB] FAIL b2b_restart: got valid=%b col %0d data %0d expected 1/0/300",
                     res_valid_o, res_col_o, res_data_o); else n_pass++;
        n_checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL b2b_no_ovf: got %b expected 0", overflow_o); else n_pass++;
        run_drain(1'b0);
        n_checks++; if (n_xfer !== 3 || x_data[0] !== 16'd300 || x_data[2] !== 16'd302 || x_last[2] !== 1'b1)
            $display("[TB] FAIL b2b_burst: got %0d xfers %0d..%0d expected 3 300..302", n_xfer, x_data[0], x_data[2]); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_target_i = '0; cmd_base_i = '0; cmd_lines_i = '0;
        beat_valid_i = 1'b0; beat_data_i = '0;
        n_cols_i = '0; res_capture_i = 1'b0; res_i = '0; res_ready_i = 1'b0;
        $display("[TB] starting sparhixcel_io_bridge bench");
        test_reset();
        test_feature_load();
        test_signal_load();
        test_weight_wrap();
        test_empty_commands();
        test_drain();
        test_drain_clamp();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
